// File: rtl/ddr3_lane_dly_pkg.sv
// Shared types and constants for the DDR3 lane delay-line sequencer.
// Tap and phase-counter widths, line-select encodings and FSM states.
package ddr3_lane_dly_pkg;

  localparam int TAP_W = 8;
  localparam int PH_W  = 8;

  localparam logic SEL_RX = 1'b0;
  localparam logic SEL_TX = 1'b1;

  typedef logic [TAP_W-1:0] tap_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOAD,
    ST_MOVE,
    ST_GAP,
    ST_POST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ddr3_lane_dly_seq_if.sv
// Request/response bus between the training logic (master) and the
// delay-line sequencer (slave).
interface ddr3_lane_dly_seq_if
  import ddr3_lane_dly_pkg::*;
();
  logic valid;
  logic ready;
  logic sel;
  logic load;
  logic dir;
  tap_t taps;
  logic done;
  logic err;

  modport master (output valid, sel, load, dir, taps, input ready, done, err);
  modport slave  (input valid, sel, load, dir, taps, output ready, done, err);
endinterface

// File: rtl/ddr3_lane_dly_sync.sv
// Two-flop synchroniser for the lane controller's asynchronous
// out-of-range flags.
module ddr3_lane_dly_sync (
  input  logic fab_clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);
  logic meta;

  always_ff @(posedge fab_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end
endmodule

// File: rtl/ddr3_lane_dly_seq.sv
// Sequences tap moves and reloads on the RX/TX DQS delay lines, wrapping each
// update in HS_IO_CLK_PAUSE and tracking the current tap of both lines.
//
// state | meaning
// IDLE  | ready for a request
// PRE   | pause asserted, setup before first strobe
// LOAD  | load strobe, selected tap back to INIT_TAP
// MOVE  | one move strobe (or saturation stop)
// GAP   | settle after a move, OOR sampled on last cycle
// POST  | pause hold after last strobe
// DONE  | completion pulse
module ddr3_lane_dly_seq
  import ddr3_lane_dly_pkg::*;
#(
  parameter tap_t INIT_TAP    = 8'd1,
  parameter tap_t MAX_TAP     = 8'd255,
  parameter int   PAUSE_SETUP = 2,
  parameter int   PAUSE_HOLD  = 2,
  parameter int   MOVE_GAP    = 4
) (
  input  logic                fab_clk,
  input  logic                reset_n,
  ddr3_lane_dly_seq_if.slave  req,
  output tap_t                rx_tap,
  output tap_t                tx_tap,
  output logic                delay_line_sel,
  output logic                delay_line_load,
  output logic                delay_line_direction,
  output logic                delay_line_move,
  output logic                hs_io_clk_pause,
  input  logic                rx_delay_line_out_of_range,
  input  logic                tx_delay_line_out_of_range
);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(PAUSE_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(PAUSE_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(MOVE_GAP - 1);

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  tap_t            rem_q, rem_d;
  tap_t            rx_tap_d, tx_tap_d, cur_tap, step_tap;
  logic            is_load_q, is_load_d;
  logic            sel_d, dir_d, err_q, err_d;
  logic            load_d, move_d, pause_d, ready_q, ready_d, done_q, done_d;
  logic            rx_oor, tx_oor, oor, at_limit;

  ddr3_lane_dly_sync u_rx_sync (
    .fab_clk  (fab_clk),
    .reset_n  (reset_n),
    .async_in (rx_delay_line_out_of_range),
    .sync_out (rx_oor)
  );

  ddr3_lane_dly_sync u_tx_sync (
    .fab_clk  (fab_clk),
    .reset_n  (reset_n),
    .async_in (tx_delay_line_out_of_range),
    .sync_out (tx_oor)
  );

  assign cur_tap  = (delay_line_sel == SEL_TX) ? tx_tap : rx_tap;
  assign oor      = (delay_line_sel == SEL_TX) ? tx_oor : rx_oor;
  assign at_limit = delay_line_direction ? (cur_tap == MAX_TAP) : (cur_tap == '0);
  assign step_tap = delay_line_direction ? cur_tap + tap_t'(1) : cur_tap - tap_t'(1);

  assign req.ready = ready_q;
  assign req.done  = done_q;
  assign req.err   = err_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    rx_tap_d  = rx_tap;
    tx_tap_d  = tx_tap;
    is_load_d = is_load_q;
    sel_d     = delay_line_sel;
    dir_d     = delay_line_direction;
    err_d     = err_q;
    load_d    = 1'b0;
    move_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req.valid) begin
          sel_d     = req.sel;
          dir_d     = req.dir;
          is_load_d = req.load;
          rem_d     = req.taps;
          err_d     = 1'b0;
          if (!req.load && req.taps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PRE;
            phase_d = SETUP_LAST;
          end
        end
      end
      ST_PRE: begin
        if (phase_q == '0) state_d = is_load_q ? ST_LOAD : ST_MOVE;
        else               phase_d = phase_q - PH_W'(1);
      end
      ST_LOAD: begin
        state_d = ST_POST;
        phase_d = HOLD_LAST;
      end
      ST_MOVE: begin
        // A move strobe in this cycle means the tap really moved; otherwise we saturated.
        if (delay_line_move) begin
          state_d = ST_GAP;
          phase_d = GAP_LAST;
        end else begin
          state_d = ST_POST;
          phase_d = HOLD_LAST;
        end
      end
      ST_GAP: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PH_W'(1);
        end else if (oor || rem_q == '0) begin
          err_d   = err_q | oor;
          state_d = ST_POST;
          phase_d = HOLD_LAST;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_POST: begin
        if (phase_q == '0) state_d = ST_DONE;
        else               phase_d = phase_q - PH_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes and tap updates are issued on entry so they line up with the registered outputs.
    if (state_d == ST_MOVE) begin
      if (at_limit) begin
        err_d = 1'b1;
      end else begin
        move_d = 1'b1;
        rem_d  = rem_q - tap_t'(1);
        if (delay_line_sel == SEL_TX) tx_tap_d = step_tap;
        else                          rx_tap_d = step_tap;
      end
    end
    if (state_d == ST_LOAD) begin
      load_d = 1'b1;
      if (delay_line_sel == SEL_TX) tx_tap_d = INIT_TAP;
      else                          rx_tap_d = INIT_TAP;
    end

    pause_d = (state_d == ST_PRE)  || (state_d == ST_LOAD) || (state_d == ST_MOVE) ||
              (state_d == ST_GAP)  || (state_d == ST_POST);
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge fab_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= ST_IDLE;
      phase_q              <= '0;
      rem_q                <= '0;
      rx_tap               <= INIT_TAP;
      tx_tap               <= INIT_TAP;
      is_load_q            <= 1'b0;
      delay_line_sel       <= 1'b0;
      delay_line_direction <= 1'b0;
      delay_line_load      <= 1'b0;
      delay_line_move      <= 1'b0;
      hs_io_clk_pause      <= 1'b0;
      err_q                <= 1'b0;
      ready_q              <= 1'b0;
      done_q               <= 1'b0;
    end else begin
      state_q              <= state_d;
      phase_q              <= phase_d;
      rem_q                <= rem_d;
      rx_tap               <= rx_tap_d;
      tx_tap               <= tx_tap_d;
      is_load_q            <= is_load_d;
      delay_line_sel       <= sel_d;
      delay_line_direction <= dir_d;
      delay_line_load      <= load_d;
      delay_line_move      <= move_d;
      hs_io_clk_pause      <= pause_d;
      err_q                <= err_d;
      ready_q              <= ready_d;
      done_q               <= done_d;
    end
  end
endmodule

// File: tb/tb_ddr3_lane_dly_seq.sv
// Self-checking bench for ddr3_lane_dly_seq: directed vector table, corner
// sequences (OOR abort, held VALID, mid-op reset) and a randomized model run.
module tb_ddr3_lane_dly_seq;
  import ddr3_lane_dly_pkg::*;

  localparam int   S = 2;
  localparam int   H = 2;
  localparam int   G = 4;
  localparam tap_t INIT = 8'd1;
  localparam tap_t MAXT = 8'd255;

  logic fab_clk = 1'b0;
  logic reset_n = 1'b0;
  tap_t rx_tap, tx_tap;
  logic delay_line_sel, delay_line_load, delay_line_direction, delay_line_move, hs_io_clk_pause;
  logic rx_oor = 1'b0;
  logic tx_oor = 1'b0;

  int checks = 0;
  int failures = 0;

  ddr3_lane_dly_seq_if bus ();

  ddr3_lane_dly_seq dut (
    .fab_clk                    (fab_clk),
    .reset_n                    (reset_n),
    .req                        (bus),
    .rx_tap                     (rx_tap),
    .tx_tap                     (tx_tap),
    .delay_line_sel             (delay_line_sel),
    .delay_line_load            (delay_line_load),
    .delay_line_direction       (delay_line_direction),
    .delay_line_move            (delay_line_move),
    .hs_io_clk_pause            (hs_io_clk_pause),
    .rx_delay_line_out_of_range (rx_oor),
    .tx_delay_line_out_of_range (tx_oor)
  );

  always #5 fab_clk = ~fab_clk;

  typedef struct {
    logic sel; logic load; logic dir; tap_t taps;
    int lat; int mv; int ld; int pz; logic err; tap_t rx; tap_t tx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request and observes it up to the DONE pulse (cycle 0 = accept edge).
  task automatic do_req(input logic s, input logic l, input logic d, input tap_t n,
                        input int oor_at, output int lat, output int mv, output int ld,
                        output int pz, output int bad);
    int last_mv;
    int w;
    lat = -1; mv = 0; ld = 0; pz = 0; bad = 0; last_mv = 0; w = 0;
    @(negedge fab_clk);
    bus.valid = 1'b1; bus.sel = s; bus.load = l; bus.dir = d; bus.taps = n;
    while (!bus.ready && w < 50) begin
      @(negedge fab_clk);
      w++;
    end
    if (!bus.ready) bad++;
    @(posedge fab_clk);
    @(negedge fab_clk);
    bus.valid = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      if (delay_line_move) begin
        mv++;
        if (mv == 1 && c != S + 1) bad++;
        if (mv > 1 && c - last_mv != 1 + G) bad++;
        last_mv = c;
        if (oor_at != 0 && mv == oor_at) begin
          if (s) tx_oor = 1'b1;
          else   rx_oor = 1'b1;
        end
      end
      if (delay_line_load) ld++;
      if (hs_io_clk_pause) pz++;
      if ((delay_line_move || delay_line_load) && !hs_io_clk_pause) bad++;
      if (hs_io_clk_pause && (delay_line_sel != s || delay_line_direction != d)) bad++;
      if (bus.ready) bad++;
      if (bus.done) begin
        if (hs_io_clk_pause) bad++;
        lat = c;
        break;
      end
      @(negedge fab_clk);
    end
  endtask

  int lat, mv, ld, pz, bad;
  int acc, dn;
  int m_rx, m_tx, cur, room, k, e_lat, e_mv, e_ld, e_err;
  logic r_sel, r_load, r_dir;
  tap_t r_n;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd3, 20, 3, 0, 19, 1'b0, 8'd4, 8'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'd8, 45, 8, 0, 44, 1'b0, 8'd4, 8'd9};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'd7,  6, 0, 1,  5, 1'b0, 8'd4, 8'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'd4, 25, 4, 0, 24, 1'b0, 8'd0, 8'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'd0,  6, 0, 1,  5, 1'b0, 8'd1, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'd4, 11, 1, 0, 10, 1'b1, 8'd0, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd2,  6, 0, 0,  5, 1'b1, 8'd0, 8'd1};

    bus.valid = 1'b0; bus.sel = 1'b0; bus.load = 1'b0; bus.dir = 1'b0; bus.taps = '0;
    repeat (3) @(negedge fab_clk);
    check("ready_in_reset", int'(bus.ready), 0);
    reset_n = 1'b1;
    @(posedge fab_clk);
    #1;
    check("ready_after_reset", int'(bus.ready), 1);
    check("rx_tap_reset", int'(rx_tap), int'(INIT));
    check("tx_tap_reset", int'(tx_tap), int'(INIT));
    check("outputs_reset", int'({hs_io_clk_pause, delay_line_move, delay_line_load, bus.done,
                                 bus.err, delay_line_sel, delay_line_direction}), 0);

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].sel, vecs[i].load, vecs[i].dir, vecs[i].taps, 0, lat, mv, ld, pz, bad);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_moves", i), mv, vecs[i].mv);
      check($sformatf("v%0d_loads", i), ld, vecs[i].ld);
      check($sformatf("v%0d_pause", i), pz, vecs[i].pz);
      check($sformatf("v%0d_err", i), int'(bus.err), int'(vecs[i].err));
      check($sformatf("v%0d_rx_tap", i), int'(rx_tap), int'(vecs[i].rx));
      check($sformatf("v%0d_tx_tap", i), int'(tx_tap), int'(vecs[i].tx));
      check($sformatf("v%0d_protocol", i), bad, 0);
    end

    repeat (4) @(negedge fab_clk);
    check("err_sticky", int'(bus.err), 1);
    do_req(1'b0, 1'b0, 1'b1, 8'd0, 0, lat, mv, ld, pz, bad);
    check("zero_latency", lat, 1);
    check("zero_pause", pz, 0);
    check("zero_err_cleared", int'(bus.err), 0);
    check("zero_protocol", bad, 0);

    do_req(1'b1, 1'b1, 1'b0, 8'd0, 0, lat, mv, ld, pz, bad);
    check("tx_reload_tap", int'(tx_tap), 1);
    do_req(1'b1, 1'b0, 1'b1, 8'd10, 2, lat, mv, ld, pz, bad);
    check("oor_moves", int'(mv == 2 || mv == 3), 1);
    check("oor_tx_tap", int'(tx_tap), 1 + mv);
    check("oor_err", int'(bus.err), 1);
    check("oor_latency", lat, S + mv * (1 + G) + H + 1);
    check("oor_pause", pz, lat - 1);
    check("oor_protocol", bad, 0);
    tx_oor = 1'b0;
    repeat (3) @(negedge fab_clk);

    // VALID held high across a whole request: only one further accept, at IDLE.
    @(negedge fab_clk);
    bus.valid = 1'b1; bus.sel = 1'b0; bus.load = 1'b0; bus.dir = 1'b1; bus.taps = 8'd2;
    @(posedge fab_clk);
    @(negedge fab_clk);
    acc = 0; dn = 0;
    for (int i = 1; i < 200 && dn < 2; i++) begin
      if (bus.ready) acc++;
      if (bus.done) dn++;
      @(negedge fab_clk);
    end
    bus.valid = 1'b0;
    check("held_valid_accepts", acc, 1);
    check("held_valid_dones", dn, 2);
    check("held_valid_rx_tap", int'(rx_tap), 4);

    // Reset in the middle of a GAP.
    @(negedge fab_clk);
    bus.valid = 1'b1; bus.sel = 1'b0; bus.load = 1'b0; bus.dir = 1'b1; bus.taps = 8'd5;
    @(posedge fab_clk);
    @(negedge fab_clk);
    bus.valid = 1'b0;
    repeat (4) @(negedge fab_clk);
    check("pre_reset_pause", int'(hs_io_clk_pause), 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", int'({hs_io_clk_pause, delay_line_move, delay_line_load,
                                    bus.done, bus.ready}), 0);
    check("midreset_rx_tap", int'(rx_tap), int'(INIT));
    repeat (2) @(negedge fab_clk);
    reset_n = 1'b1;
    @(posedge fab_clk);
    #1;
    check("midreset_ready", int'(bus.ready), 1);
    do_req(1'b0, 1'b0, 1'b1, 8'd1, 0, lat, mv, ld, pz, bad);
    check("post_reset_latency", lat, S + (1 + G) + H + 1);
    check("post_reset_rx_tap", int'(rx_tap), 2);
    check("post_reset_protocol", bad, 0);

    m_rx = 2; m_tx = 1;
    for (int i = 0; i < 30; i++) begin
      r_sel  = 1'($urandom_range(0, 1));
      r_load = ($urandom_range(0, 7) == 0);
      r_dir  = 1'($urandom_range(0, 1));
      r_n    = tap_t'($urandom_range(0, 10));
      cur = r_sel ? m_tx : m_rx;
      e_mv = 0; e_ld = 0; e_err = 0;
      if (r_load) begin
        cur = int'(INIT); e_ld = 1; e_lat = S + H + 2;
      end else if (r_n == 0) begin
        e_lat = 1;
      end else begin
        room  = r_dir ? int'(MAXT) - cur : cur;
        k     = (int'(r_n) < room) ? int'(r_n) : room;
        e_err = (k < int'(r_n)) ? 1 : 0;
        cur   = r_dir ? cur + k : cur - k;
        e_mv  = k;
        e_lat = S + k * (1 + G) + e_err + H + 1;
      end
      if (r_sel) m_tx = cur;
      else       m_rx = cur;
      do_req(r_sel, r_load, r_dir, r_n, 0, lat, mv, ld, pz, bad);
      check($sformatf("rnd%0d_latency", i), lat, e_lat);
      check($sformatf("rnd%0d_moves", i), mv, e_mv);
      check($sformatf("rnd%0d_loads", i), ld, e_ld);
      check($sformatf("rnd%0d_pause", i), pz, (e_lat == 1) ? 0 : e_lat - 1);
      check($sformatf("rnd%0d_err", i), int'(bus.err), e_err);
      check($sformatf("rnd%0d_rx_tap", i), int'(rx_tap), m_rx);
      check($sformatf("rnd%0d_tx_tap", i), int'(tx_tap), m_tx);
      check($sformatf("rnd%0d_protocol", i), bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
